// File: rtl/decoder_scan_nto2n.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan_nto2n
// Brief    : Registered N-to-2^N one-hot decoder, direct decode or timed scan.
//            DECODER_SCAN_ACTIVE_LOW_EN inverts the out pin (active-low strobe).
// Revision : 1.0 - initial release
// ============================================================================
module decoder_scan_nto2n #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam int                 c_cnt_w    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DWELL - 1);
  localparam logic [SEL_W-1:0]   c_idx_last = SEL_W'(OUT_W - 1);

  if (SEL_W < 1 || SEL_W > 6 || DWELL < 1 || DWELL > 65536 ||
      OUT_W != (1 << SEL_W)) begin : g_param_check
    $error("decoder_scan_nto2n: illegal SEL_W/OUT_W/DWELL");
  end

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_direct = 2'd1,
    st_scan   = 2'd2
  } state_t;

  state_t             r_state;
  logic [OUT_W-1:0]   r_out;
  logic               r_valid;
  logic [SEL_W-1:0]   r_idx;
  logic               r_wrap;
  logic [c_cnt_w-1:0] r_cnt;
  logic [SEL_W-1:0]   w_idx_inc;

  assign in_ready  = rst_n & en & ~mode;
  assign w_idx_inc = r_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= st_idle;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else if (!en) begin
      // idx deliberately holds so software can see where blanking happened
      r_state <= st_idle;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else if (mode) begin
      r_valid <= 1'b1;
      if (r_state != st_scan) begin
        r_state <= st_scan;
        r_out   <= OUT_W'(1);
        r_idx   <= '0;
        r_cnt   <= '0;
        r_wrap  <= 1'b0;
      end else if (r_cnt == c_cnt_last) begin
        r_cnt   <= '0;
        r_idx   <= w_idx_inc;
        r_out   <= OUT_W'(1) << w_idx_inc;
        r_wrap  <= (r_idx == c_idx_last);
      end else begin
        r_cnt   <= r_cnt + c_cnt_w'(1);
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
      r_cnt  <= '0;
      if (in_valid) begin
        r_state <= st_direct;
        r_out   <= OUT_W'(1) << sel;
        r_idx   <= sel;
        r_valid <= 1'b1;
      end else if (r_state == st_scan) begin
        // leaving scan keeps the last strobe until a new select arrives
        r_state <= st_direct;
      end
    end
  end

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  assign out = ~r_out;
`else
  assign out = r_out;
`endif
  assign out_valid = r_valid;
  assign idx       = r_idx;
  assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_nto2n.sv
`default_nettype none
// Bench for decoder_scan_nto2n: two instances (3-bit/DWELL 4, 2-bit/DWELL 1)
// driven together and compared each cycle against a cycle-count reference model.
module tb_decoder_scan_nto2n;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, in_valid;
  logic [2:0] sel;

  logic       in_ready_a, out_valid_a, wrap_a;
  logic [7:0] out_a;
  logic [2:0] idx_a;
  logic       in_ready_b, out_valid_b, wrap_b;
  logic [3:0] out_b;
  logic [1:0] idx_b;

  always #5 clk = ~clk;

  decoder_scan_nto2n #(.SEL_W(3), .DWELL(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready_a), .sel(sel), .out(out_a), .out_valid(out_valid_a),
    .idx(idx_a), .wrap(wrap_a)
  );

  decoder_scan_nto2n #(.SEL_W(2), .DWELL(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready_b), .sel(sel[1:0]), .out(out_b), .out_valid(out_valid_b),
    .idx(idx_b), .wrap(wrap_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: scan position is the cycle count since scan entry.
  int c_dw[2] = '{4, 1};
  int c_w[2]  = '{8, 4};
  bit m_scan[2]  = '{0, 0};
  int m_t[2]     = '{0, 0};
  int m_idx[2]   = '{0, 0};
  bit m_valid[2] = '{0, 0};
  bit m_wrap[2]  = '{0, 0};

  function automatic logic [31:0] pol(input int w, input logic [31:0] v);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    return ~v & ((32'd1 << w) - 32'd1);
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] exp_out(input int k);
    logic [31:0] v;
    v = m_valid[k] ? (32'd1 << m_idx[k]) : 32'd0;
    return pol(c_w[k], v);
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_scan[k] = 0; m_t[k] = 0; m_idx[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
      end else if (!en) begin
        m_scan[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
      end else if (mode) begin
        if (!m_scan[k]) begin
          m_scan[k] = 1;
          m_t[k] = 0;
        end else begin
          m_t[k]++;
        end
        m_idx[k]   = (m_t[k] / c_dw[k]) % c_w[k];
        m_valid[k] = 1;
        m_wrap[k]  = (m_t[k] != 0) && (m_t[k] % (c_dw[k] * c_w[k]) == 0);
      end else begin
        m_scan[k] = 0;
        m_wrap[k] = 0;
        if (in_valid) begin
          m_idx[k]   = int'(sel) % c_w[k];
          m_valid[k] = 1;
        end
      end
    end
  endtask

  // Inputs are set at the negedge; this advances one clock and checks everything.
  task automatic cycle();
    logic rdy;
    #1;
    rdy = rst_n & en & ~mode;
    check("a.in_ready", in_ready_a, rdy);
    check("b.in_ready", in_ready_b, rdy);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("a.out", out_a, exp_out(0));
    check("a.out_valid", out_valid_a, m_valid[0]);
    check("a.idx", idx_a, m_idx[0]);
    check("a.wrap", wrap_a, m_wrap[0]);
    check("b.out", out_b, exp_out(1));
    check("b.out_valid", out_valid_b, m_valid[1]);
    check("b.idx", idx_b, m_idx[1]);
    check("b.wrap", wrap_b, m_wrap[1]);
  endtask

  initial begin
    int wraps;
    int wrap_at;
    int guard;

    rst_n = 1'b0; en = 1'b1; mode = 1'b1; in_valid = 1'b1; sel = 3'd5;
    @(negedge clk);

    // reset held 3 cycles with enable and scan requested
    for (int i = 0; i < 3; i++) cycle();
    check("reset.out", out_a, pol(8, 0));
    check("reset.idx", idx_a, 0);

    // direct decode, back-to-back accepts
    rst_n = 1'b1; mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      cycle();
      check("direct.out", out_a, pol(8, 32'd1 << i));
      check("direct.idx", idx_a, i);
    end
    in_valid = 1'b0;

    // scan for 40 cycles, wrap exactly once on cycle 33
    mode = 1'b1; wraps = 0; wrap_at = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (i <= 4) check("scan.first", out_a, pol(8, 1));
      if (wrap_a) begin
        wraps++;
        wrap_at = i;
      end
    end
    check("scan.wrap_count", wraps, 1);
    check("scan.wrap_cycle", wrap_at, 33);

    // blanking mid-scan at idx 5, then restart from 0
    guard = 0;
    while (m_idx[0] != 5 && guard < 64) begin
      cycle();
      guard++;
    end
    check("blank.reach_idx5", (m_idx[0] == 5), 1);
    en = 1'b0;
    cycle();
    check("blank.out", out_a, pol(8, 0));
    check("blank.idx", idx_a, 5);
    check("blank.b_out", out_b, pol(4, 0));
    en = 1'b1;
    cycle();
    check("blank.restart", idx_a, 0);

    // scan to idx 3 with in_valid ignored, then switch to direct
    in_valid = 1'b1; sel = 3'd6;
    guard = 0;
    while (m_idx[0] != 3 && guard < 64) begin
      cycle();
      guard++;
    end
    check("mswitch.reach_idx3", idx_a, 3);
    mode = 1'b0; in_valid = 1'b0;
    cycle();
    check("mswitch.hold", out_a, pol(8, 8'h08));
    in_valid = 1'b1;
    cycle();
    check("mswitch.accept", out_a, pol(8, 8'h40));
    in_valid = 1'b0;

    // randomized traffic with sticky mode
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      in_valid = 1'($urandom);
      sel      = 3'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
